// File: rtl/oc_wormhole_arbiter.sv
// Wormhole output-channel allocator: round-robin grant across IN_N virtual channels,
// held from header to tail, with a stall watchdog that frees locks held by dead owners.
module oc_wormhole_arbiter #(
    parameter int IN_N      = 5,
    parameter int FLIT_W    = 10,
    parameter int TIMEOUT_W = 6
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [IN_N-1:0]          req_i,
    input  logic [IN_N-1:0]          tail_i,
    input  logic [IN_N-1:0]          vld_i,
    input  logic [IN_N*FLIT_W-1:0]   data_i,
    input  logic                     oc_rdy_i,
    output logic [IN_N-1:0]          grant_o,
    output logic [FLIT_W-1:0]        data_o,
    output logic                     vld_o,
    output logic                     busy_o,
    output logic                     err_o
);

    localparam int OW = (IN_N > 1) ? $clog2(IN_N) : 1;
    localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;
    localparam logic [OW-1:0] RR_RST = OW'(IN_N - 1);
    localparam logic [IN_N-1:0] ONE_HOT0 = {{(IN_N-1){1'b0}}, 1'b1};

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t               state_q, state_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic [OW-1:0]        rr_q, rr_d;
    logic [IN_N-1:0]      grant_q, grant_d;
    logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
    logic [OW-1:0]        win, arb_idx;
    logic                 win_vld;
    logic                 locked, xfer, timeout;
    logic [FLIT_W-1:0]    owner_flit;

    // Search upward from the slot after the last owner, wrapping at IN_N.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        arb_idx = '0;
        for (int i = 1; i <= IN_N; i++) begin
            arb_idx = OW'((int'(rr_q) + i) % IN_N);
            if (!win_vld && req_i[arb_idx]) begin
                win     = arb_idx;
                win_vld = 1'b1;
            end
        end
    end

    assign locked     = (state_q == ST_LOCKED);
    assign xfer       = vld_i[owner_q] & oc_rdy_i;
    assign timeout    = locked & ~xfer & (wdog_q == WD_MAX);
    assign owner_flit = data_i[int'(owner_q)*FLIT_W +: FLIT_W];

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        wdog_d  = wdog_q;
        case (state_q)
            ST_IDLE: begin
                wdog_d = '0;
                if (win_vld) begin
                    state_d = ST_LOCKED;
                    owner_d = win;
                    grant_d = ONE_HOT0 << win;
                end
            end
            ST_LOCKED: begin
                if ((xfer && tail_i[owner_q]) || timeout) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    rr_d    = owner_q;
                    wdog_d  = '0;
                end else if (xfer) begin
                    wdog_d = '0;
                end else if (wdog_q != WD_MAX) begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            rr_q    <= RR_RST;
            grant_q <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            wdog_q  <= wdog_d;
        end
    end

    assign grant_o = grant_q;
    assign vld_o   = locked & xfer;
    assign data_o  = vld_o ? owner_flit : '0;
    assign busy_o  = locked;
    assign err_o   = timeout;

endmodule

// File: tb/tb_oc_wormhole_arbiter.sv
// Directed bench for oc_wormhole_arbiter: reset, round-robin, wormhole hold,
// backpressure, single-flit release, watchdog timeout and asynchronous reset.
module tb_oc_wormhole_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [4:0]  req_i, tail_i, vld_i;
    logic [49:0] data_i;
    logic        oc_rdy_i;
    logic [4:0]  grant_o;
    logic [9:0]  data_o;
    logic        vld_o, busy_o, err_o;

    int total = 0;
    int bad   = 0;

    oc_wormhole_arbiter #(.IN_N(5), .FLIT_W(10), .TIMEOUT_W(3)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .tail_i(tail_i), .vld_i(vld_i),
        .data_i(data_i), .oc_rdy_i(oc_rdy_i), .grant_o(grant_o), .data_o(data_o),
        .vld_o(vld_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL time_limit obs=running exp=finished");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One packet from owner w, n flits, tail on the last; noise drives non-owner vld/tail.
    task automatic run_pkt(input int w, input int n, input logic [4:0] noise);
        for (int f = 0; f < n; f++) begin
            logic [9:0] d;
            d = 10'(w*64 + f + 1);
            data_i = {5{10'h3FF}};
            data_i[w*10 +: 10] = d;
            vld_i  = (5'b1 << w) | noise;
            tail_i = ((f == n-1) ? (5'b1 << w) : 5'b0) | (noise & ~(5'b1 << w));
            #1;
            chk("pkt_grant", 16'(grant_o), 16'(5'b1 << w));
            chk("pkt_vld",   16'(vld_o),   16'd1);
            chk("pkt_data",  16'(data_o),  16'(d));
            tick();
        end
        vld_i  = '0;
        tail_i = '0;
    endtask

    initial begin
        rst_ni = 1'b0; req_i = 5'b11111; tail_i = '0; vld_i = '0; data_i = '0; oc_rdy_i = 1'b1;

        // reset
        tick(); tick();
        chk("rst_grant", 16'(grant_o), 16'h0);
        chk("rst_vld",   16'(vld_o),   16'h0);
        chk("rst_err",   16'(err_o),   16'h0);
        chk("rst_busy",  16'(busy_o),  16'h0);
        rst_ni = 1'b1;
        #1;
        chk("rel_grant0", 16'(grant_o), 16'h0);
        tick();
        chk("rel_grant1", 16'(grant_o), 16'b00001);
        req_i = '0;
        run_pkt(0, 1, 5'b0);
        chk("vc0_release", 16'(grant_o), 16'h0);

        // round-robin over 10110
        req_i = 5'b10110;
        #1;
        chk("rr_idle", 16'(grant_o), 16'h0);
        tick();
        chk("rr_g1", 16'(grant_o), 16'b00010);
        run_pkt(1, 3, 5'b0);
        chk("rr_gap1", 16'(grant_o), 16'h0);
        chk("rr_gap1_busy", 16'(busy_o), 16'h0);
        tick();
        chk("rr_g2", 16'(grant_o), 16'b00100);
        run_pkt(2, 3, 5'b0);
        chk("rr_gap2", 16'(grant_o), 16'h0);
        tick();
        chk("rr_g3", 16'(grant_o), 16'b10000);
        run_pkt(4, 3, 5'b0);
        tick();
        chk("rr_g4", 16'(grant_o), 16'b00010);

        // wormhole hold: VC3 requests mid-packet, non-owner vld/tail noise
        req_i = 5'b01000;
        run_pkt(1, 3, 5'b01001);
        chk("hold_gap", 16'(grant_o), 16'h0);
        tick();
        chk("hold_vc3", 16'(grant_o), 16'b01000);
        req_i = '0;

        // tail without vld does not release
        tail_i = 5'b01000; vld_i = '0;
        #1;
        chk("tail_novld_vld", 16'(vld_o), 16'h0);
        tick();
        chk("tail_novld_busy", 16'(busy_o), 16'h1);
        chk("tail_novld_grant", 16'(grant_o), 16'b01000);

        // backpressure: rdy 1,0,0,1 then two more flits
        tail_i = '0; vld_i = 5'b01000; data_i = {5{10'h3FF}};
        data_i[30 +: 10] = 10'h0C1; oc_rdy_i = 1'b1;
        #1;
        chk("bp_f0_vld",  16'(vld_o),  16'h1);
        chk("bp_f0_data", 16'(data_o), 16'h0C1);
        tick();
        data_i[30 +: 10] = 10'h0C2; oc_rdy_i = 1'b0;
        #1;
        chk("bp_s1_vld",  16'(vld_o),  16'h0);
        chk("bp_s1_data", 16'(data_o), 16'h0);
        tick();
        chk("bp_s2_vld",  16'(vld_o),  16'h0);
        chk("bp_s2_data", 16'(data_o), 16'h0);
        chk("bp_s2_grant", 16'(grant_o), 16'b01000);
        tick();
        oc_rdy_i = 1'b1;
        #1;
        chk("bp_f1_vld",  16'(vld_o),  16'h1);
        chk("bp_f1_data", 16'(data_o), 16'h0C2);
        tick();
        data_i[30 +: 10] = 10'h0C3;
        #1;
        chk("bp_f2_data", 16'(data_o), 16'h0C3);
        tick();
        data_i[30 +: 10] = 10'h0C4; tail_i = 5'b01000;
        #1;
        chk("bp_f3_data", 16'(data_o), 16'h0C4);
        tick();
        vld_i = '0; tail_i = '0;
        chk("bp_done_busy", 16'(busy_o), 16'h0);

        // no requests in IDLE, then single-flit packet
        tick(); tick();
        chk("empty_grant", 16'(grant_o), 16'h0);
        req_i = 5'b00001;
        tick();
        chk("sf_grant", 16'(grant_o), 16'b00001);
        req_i = '0; vld_i = 5'b00001; tail_i = 5'b00001; data_i[0 +: 10] = 10'h2A5;
        #1;
        chk("sf_vld",  16'(vld_o),  16'h1);
        chk("sf_data", 16'(data_o), 16'h2A5);
        tick();
        vld_i = '0; tail_i = '0;
        chk("sf_release", 16'(grant_o), 16'h0);
        req_i = 5'b00011;
        tick();
        chk("sf_rrptr", 16'(grant_o), 16'b00010);

        // watchdog: VC1 never sends
        req_i = 5'b10001;
        for (int k = 0; k < 7; k++) begin
            chk("wd_quiet", 16'(err_o), 16'h0);
            tick();
        end
        chk("wd_err",   16'(err_o),   16'h1);
        chk("wd_busy",  16'(busy_o),  16'h1);
        tick();
        chk("wd_err_off", 16'(err_o),   16'h0);
        chk("wd_grant0",  16'(grant_o), 16'h0);
        tick();
        chk("wd_next", 16'(grant_o), 16'b10000);

        // asynchronous reset mid-lock
        rst_ni = 1'b0;
        #1;
        chk("arst_grant", 16'(grant_o), 16'h0);
        chk("arst_busy",  16'(busy_o),  16'h0);
        tick();
        rst_ni = 1'b1;
        tick();
        chk("arst_regrant", 16'(grant_o), 16'b00001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
